// File: rtl/instruction_fetch_unit_if.sv
// Fetch-stage bus: instruction-memory request/response plus the decode handshake.
// Decode handshake: an entry transfers on every rising edge where if_valid && if_ready;
// if_valid never depends on if_ready, and the head stays stable until it is accepted or flushed.
interface instruction_fetch_unit_if #(
  parameter int addr_bits = 8
);
  logic                 imem_read_enable;
  logic [addr_bits-1:0] imem_address;
  logic [31:0]          imem_data;
  logic                 branch_taken;
  logic [31:0]          branch_target;
  logic                 if_valid;
  logic                 if_ready;
  logic [31:0]          if_instruction;
  logic [31:0]          if_pc;

  modport master (
    output imem_read_enable,
    output imem_address,
    input  imem_data,
    input  branch_taken,
    input  branch_target,
    output if_valid,
    input  if_ready,
    output if_instruction,
    output if_pc
  );

  modport slave (
    input  imem_read_enable,
    input  imem_address,
    output imem_data,
    output branch_taken,
    output branch_target,
    input  if_valid,
    output if_ready,
    input  if_instruction,
    input  if_pc
  );
endinterface

// File: rtl/instruction_fetch_unit.sv
// RISC-V fetch stage: owns the PC, issues synchronous-read requests, buffers returning
// words in a 2-entry FIFO and hands {pc, instruction} to decode; branch redirect flushes.
module instruction_fetch_unit #(
  parameter int          memory_size         = 1024,
  parameter int          memory_address_bits = $clog2(memory_size),
  parameter logic [31:0] reset_pc            = 32'h0000_0000
) (
  input  logic                     clk,
  input  logic                     rst_n,
  instruction_fetch_unit_if.master bus,
  output logic [1:0]               state_dbg
);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_RUN      = 2'd1,
    ST_FULL     = 2'd2,
    ST_REDIRECT = 2'd3
  } state_e;

  state_e           state_q, state_d;
  logic [31:0]      pc_q, pc_d;
  logic             pending_q, pending_d;
  logic [31:0]      pending_pc_q, pending_pc_d;
  logic [1:0][31:0] buf_pc_q, buf_pc_d;
  logic [1:0][31:0] buf_instr_q, buf_instr_d;
  logic             head_q, head_d;
  logic             tail_q, tail_d;
  logic [1:0]       count_q, count_d;

  logic             pop;
  logic             push;
  logic             issue_allowed;
  logic             issue;
  logic [2:0]       occupancy;
  logic             unused_target_bits;

  assign unused_target_bits = ^bus.branch_target[1:0];

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    state_d = state_q;
    if (bus.branch_taken) begin
      state_d = ST_REDIRECT;
    end else begin
      case (state_q)
        ST_IDLE:     state_d = ST_RUN;
        ST_RUN:      if (count_q == 2'd2 && !bus.if_ready) state_d = ST_FULL;
        ST_FULL:     if (pop) state_d = ST_RUN;
        ST_REDIRECT: state_d = ST_RUN;
        default:     state_d = ST_IDLE;
      endcase
    end
  end

  // ---------------- FSM: outputs ----------------
  always_comb begin
    issue_allowed = 1'b0;
    case (state_q)
      ST_RUN, ST_REDIRECT: issue_allowed = 1'b1;
      default:             issue_allowed = 1'b0;
    endcase
  end

  assign state_dbg = state_q;

  // ---------------- handshake and issue decisions ----------------
  assign pop  = (count_q != 2'd0) && bus.if_ready;
  assign push = pending_q && !bus.branch_taken;

  // Counting the in-flight word as occupied means returning data always has a free slot.
  assign occupancy = {1'b0, count_q} + {2'b00, pending_q} - {2'b00, pop};
  assign issue     = issue_allowed && !bus.branch_taken && (occupancy < 3'd2);

  // ---------------- datapath next state ----------------
  always_comb begin
    pc_d         = pc_q;
    pending_d    = pending_q;
    pending_pc_d = pending_pc_q;
    buf_pc_d     = buf_pc_q;
    buf_instr_d  = buf_instr_q;
    head_d       = head_q;
    tail_d       = tail_q;
    count_d      = count_q;

    if (bus.branch_taken) begin
      // Flush wins: buffered entries and the word returning next cycle are dropped.
      pc_d      = {bus.branch_target[31:2], 2'b00};
      pending_d = 1'b0;
      head_d    = 1'b0;
      tail_d    = 1'b0;
      count_d   = 2'd0;
    end else begin
      if (push) begin
        buf_pc_d[tail_q]    = pending_pc_q;
        buf_instr_d[tail_q] = bus.imem_data;
        tail_d              = ~tail_q;
      end
      if (pop) begin
        head_d = ~head_q;
      end
      count_d   = count_q + {1'b0, push} - {1'b0, pop};
      pending_d = issue;
      if (issue) begin
        pending_pc_d = pc_q;
        pc_d         = pc_q + 32'd4;
      end
    end
  end

  // ---------------- datapath registers ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q         <= reset_pc;
      pending_q    <= 1'b0;
      pending_pc_q <= 32'd0;
      buf_pc_q     <= '0;
      buf_instr_q  <= '0;
      head_q       <= 1'b0;
      tail_q       <= 1'b0;
      count_q      <= 2'd0;
    end else begin
      pc_q         <= pc_d;
      pending_q    <= pending_d;
      pending_pc_q <= pending_pc_d;
      buf_pc_q     <= buf_pc_d;
      buf_instr_q  <= buf_instr_d;
      head_q       <= head_d;
      tail_q       <= tail_d;
      count_q      <= count_d;
    end
  end

  // ---------------- outputs ----------------
  assign bus.imem_read_enable = issue;
  assign bus.imem_address     = pc_q[memory_address_bits-1:2];
  assign bus.if_valid         = (count_q != 2'd0);
  assign bus.if_pc            = buf_pc_q[head_q];
  assign bus.if_instruction   = buf_instr_q[head_q];

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for instruction_fetch_unit: streaming, backpressure, redirects,
// address wrap and asynchronous reset, with a memory model returning word = word_address*4+1.
module tb_instruction_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  state_dbg;
  logic [1:0]  state_dbg_w;
  int          checks = 0;
  int          failures = 0;
  logic [31:0] exp_q[$];
  logic [31:0] e;

  instruction_fetch_unit_if #(.addr_bits(8)) bus ();
  instruction_fetch_unit_if #(.addr_bits(8)) wbus ();

  instruction_fetch_unit #(.memory_size(1024), .reset_pc(32'h0000_0000)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus), .state_dbg(state_dbg)
  );

  instruction_fetch_unit #(.memory_size(1024), .reset_pc(32'h0000_03FC)) dut_w (
    .clk(clk), .rst_n(rst_n), .bus(wbus), .state_dbg(state_dbg_w)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- synchronous-read memory models ----------------
  always @(posedge clk) begin
    if (bus.imem_read_enable) bus.imem_data <= {22'd0, bus.imem_address, 2'b00} + 32'd1;
  end
  always @(posedge clk) begin
    if (wbus.imem_read_enable) wbus.imem_data <= {22'd0, wbus.imem_address, 2'b00} + 32'd1;
  end

  // ---------------- driver tasks ----------------
  // Leaves the bench in cycle 0 (first cycle after release) just after a falling edge.
  task automatic do_reset();
    rst_n = 1'b0;
    bus.if_ready = 1'b1;
    bus.branch_taken = 1'b0;
    bus.branch_target = 32'd0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    #1;
    checks++; if (bus.if_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%0b exp=0", bus.if_valid); end
    checks++; if (bus.imem_read_enable !== 1'b0) begin failures++; $display("FAIL reset_re got=%0b exp=0", bus.imem_read_enable); end
    checks++; if (bus.if_pc !== 32'd0) begin failures++; $display("FAIL reset_pc got=%h exp=0", bus.if_pc); end
    checks++; if (bus.if_instruction !== 32'd0) begin failures++; $display("FAIL reset_instr got=%h exp=0", bus.if_instruction); end
    checks++; if (state_dbg !== 2'd0) begin failures++; $display("FAIL reset_state got=%0d exp=0", state_dbg); end
    do_reset();
    #1;
    checks++; if (bus.imem_read_enable !== 1'b0) begin failures++; $display("FAIL idle_re got=%0b exp=0", bus.imem_read_enable); end
    checks++; if (state_dbg !== 2'd0) begin failures++; $display("FAIL idle_state got=%0d exp=0", state_dbg); end
  endtask

  task automatic test_stream();
    do_reset();
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk); #1;
      checks++; if (bus.imem_read_enable !== 1'b1 || bus.imem_address !== 8'(c-1)) begin
        failures++; $display("FAIL stream_req c=%0d got re=%0b addr=%0d exp re=1 addr=%0d", c, bus.imem_read_enable, bus.imem_address, c-1);
      end
      checks++; if (bus.if_valid !== (c >= 3)) begin
        failures++; $display("FAIL stream_valid c=%0d got=%0b exp=%0b", c, bus.if_valid, c >= 3);
      end
      if (c >= 3) begin
        checks++; if (bus.if_pc !== 32'((c-3)*4) || bus.if_instruction !== 32'((c-3)*4+1)) begin
          failures++; $display("FAIL stream_data c=%0d got pc=%h instr=%h exp pc=%h", c, bus.if_pc, bus.if_instruction, 32'((c-3)*4));
        end
      end
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    exp_q.delete();
    for (int i = 0; i < 8; i++) exp_q.push_back(32'(i*4));
    for (int c = 1; c <= 16; c++) begin
      @(negedge clk);
      bus.if_ready = !(c >= 4 && c <= 8);
      #1;
      checks++; if (bus.imem_read_enable !== !(c >= 4 && c <= 9)) begin
        failures++; $display("FAIL bp_re c=%0d got=%0b exp=%0b", c, bus.imem_read_enable, !(c >= 4 && c <= 9));
      end
      if (c >= 6 && c <= 9) begin
        checks++; if (state_dbg !== 2'd2) begin failures++; $display("FAIL bp_full_state c=%0d got=%0d exp=2", c, state_dbg); end
      end
      if (c >= 4 && c <= 8) begin
        checks++; if (bus.if_valid !== 1'b1 || bus.if_pc !== 32'd4) begin
          failures++; $display("FAIL bp_hold c=%0d got valid=%0b pc=%h exp valid=1 pc=4", c, bus.if_valid, bus.if_pc);
        end
      end
      if (c == 10) begin
        checks++; if (bus.imem_address !== 8'd3) begin failures++; $display("FAIL bp_resume_addr got=%0d exp=3", bus.imem_address); end
      end
      if (c == 11) begin
        checks++; if (bus.if_valid !== 1'b0) begin failures++; $display("FAIL bp_gap_valid got=%0b exp=0", bus.if_valid); end
      end
      if (bus.if_valid === 1'b1 && bus.if_ready === 1'b1) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++; $display("FAIL bp_extra c=%0d got pc=%h exp none", c, bus.if_pc);
        end else begin
          e = exp_q.pop_front();
          if (bus.if_pc !== e || bus.if_instruction !== e + 32'd1) begin
            failures++; $display("FAIL bp_order c=%0d got pc=%h instr=%h exp pc=%h", c, bus.if_pc, bus.if_instruction, e);
          end
        end
      end
    end
    checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL bp_missing got_left=%0d exp=0", exp_q.size()); end
  endtask

  task automatic test_redirect();
    do_reset();
    exp_q.delete();
    exp_q.push_back(32'h0); exp_q.push_back(32'h4); exp_q.push_back(32'h100); exp_q.push_back(32'h104);
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      bus.branch_taken = (c == 4);
      bus.branch_target = 32'h0000_0103;
      #1;
      if (c == 4) begin
        checks++; if (bus.imem_read_enable !== 1'b0) begin failures++; $display("FAIL redir_noissue got=%0b exp=0", bus.imem_read_enable); end
      end
      if (c == 5) begin
        checks++; if (bus.imem_read_enable !== 1'b1 || bus.imem_address !== 8'h40) begin
          failures++; $display("FAIL redir_req got re=%0b addr=%h exp re=1 addr=40", bus.imem_read_enable, bus.imem_address);
        end
        checks++; if (bus.if_valid !== 1'b0) begin failures++; $display("FAIL redir_valid got=%0b exp=0", bus.if_valid); end
        checks++; if (state_dbg !== 2'd3) begin failures++; $display("FAIL redir_state got=%0d exp=3", state_dbg); end
      end
      if (c == 6) begin
        checks++; if (bus.if_valid !== 1'b0) begin failures++; $display("FAIL redir_valid2 got=%0b exp=0", bus.if_valid); end
      end
      if (bus.if_valid === 1'b1) begin
        checks++; if (bus.if_instruction === 32'h9) begin failures++; $display("FAIL redir_stale c=%0d got=%h exp not 9", c, bus.if_instruction); end
      end
      if (bus.if_valid === 1'b1 && bus.if_ready === 1'b1) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++; $display("FAIL redir_extra c=%0d got pc=%h exp none", c, bus.if_pc);
        end else begin
          e = exp_q.pop_front();
          if (bus.if_pc !== e || bus.if_instruction !== e + 32'd1) begin
            failures++; $display("FAIL redir_order c=%0d got pc=%h instr=%h exp pc=%h", c, bus.if_pc, bus.if_instruction, e);
          end
        end
      end
    end
    checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL redir_missing got_left=%0d exp=0", exp_q.size()); end
  endtask

  task automatic test_redirect_full_pop();
    do_reset();
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      bus.if_ready = !(c >= 4 && c <= 5);
      bus.branch_taken = (c == 6);
      bus.branch_target = 32'h0000_0200;
      #1;
      if (c == 6) begin
        checks++; if (bus.if_valid !== 1'b1 || bus.if_pc !== 32'd4 || bus.imem_read_enable !== 1'b0) begin
          failures++; $display("FAIL rfp_head got valid=%0b pc=%h re=%0b exp valid=1 pc=4 re=0", bus.if_valid, bus.if_pc, bus.imem_read_enable);
        end
      end
      if (c == 7) begin
        checks++; if (bus.if_valid !== 1'b0) begin failures++; $display("FAIL rfp_valid got=%0b exp=0", bus.if_valid); end
        checks++; if (bus.imem_read_enable !== 1'b1 || bus.imem_address !== 8'h80) begin
          failures++; $display("FAIL rfp_req got re=%0b addr=%h exp re=1 addr=80", bus.imem_read_enable, bus.imem_address);
        end
      end
      if (c == 9) begin
        checks++; if (bus.if_valid !== 1'b1 || bus.if_pc !== 32'h200 || bus.if_instruction !== 32'h201) begin
          failures++; $display("FAIL rfp_target got valid=%0b pc=%h instr=%h exp valid=1 pc=200 instr=201", bus.if_valid, bus.if_pc, bus.if_instruction);
        end
      end
      if (c >= 7 && bus.if_valid === 1'b1) begin
        checks++; if (bus.if_pc === 32'd8) begin failures++; $display("FAIL rfp_discarded c=%0d got pc=%h exp not 8", c, bus.if_pc); end
      end
    end
  endtask

  task automatic test_wrap();
    do_reset();
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk); #1;
      if (c == 1) begin
        checks++; if (wbus.imem_read_enable !== 1'b1 || wbus.imem_address !== 8'd255) begin
          failures++; $display("FAIL wrap_addr1 got re=%0b addr=%0d exp re=1 addr=255", wbus.imem_read_enable, wbus.imem_address);
        end
      end
      if (c == 2) begin
        checks++; if (wbus.imem_read_enable !== 1'b1 || wbus.imem_address !== 8'd0) begin
          failures++; $display("FAIL wrap_addr2 got re=%0b addr=%0d exp re=1 addr=0", wbus.imem_read_enable, wbus.imem_address);
        end
      end
      if (c == 3) begin
        checks++; if (wbus.if_valid !== 1'b1 || wbus.if_pc !== 32'h3FC || wbus.if_instruction !== 32'h3FD) begin
          failures++; $display("FAIL wrap_pc1 got valid=%0b pc=%h instr=%h exp pc=3fc instr=3fd", wbus.if_valid, wbus.if_pc, wbus.if_instruction);
        end
      end
      if (c == 4) begin
        checks++; if (wbus.if_valid !== 1'b1 || wbus.if_pc !== 32'h400 || wbus.if_instruction !== 32'h1) begin
          failures++; $display("FAIL wrap_pc2 got valid=%0b pc=%h instr=%h exp pc=400 instr=1", wbus.if_valid, wbus.if_pc, wbus.if_instruction);
        end
      end
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk); #1;
    end
    checks++; if (bus.if_valid !== 1'b1 || bus.imem_read_enable !== 1'b1) begin
      failures++; $display("FAIL ar_before got valid=%0b re=%0b exp 1 1", bus.if_valid, bus.imem_read_enable);
    end
    #1 rst_n = 1'b0;
    #1;
    checks++; if (bus.if_valid !== 1'b0 || bus.imem_read_enable !== 1'b0 || state_dbg !== 2'd0) begin
      failures++; $display("FAIL ar_drop got valid=%0b re=%0b state=%0d exp 0 0 0", bus.if_valid, bus.imem_read_enable, state_dbg);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk); #1;
      if (c == 1) begin
        checks++; if (bus.imem_read_enable !== 1'b1 || bus.imem_address !== 8'd0) begin
          failures++; $display("FAIL ar_restart got re=%0b addr=%0d exp re=1 addr=0", bus.imem_read_enable, bus.imem_address);
        end
      end
      if (c == 3 || c == 4) begin
        checks++; if (bus.if_valid !== 1'b1 || bus.if_pc !== 32'((c-3)*4) || bus.if_instruction !== 32'((c-3)*4+1)) begin
          failures++; $display("FAIL ar_stream c=%0d got valid=%0b pc=%h instr=%h exp pc=%h", c, bus.if_valid, bus.if_pc, bus.if_instruction, 32'((c-3)*4));
        end
      end
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    bus.if_ready = 1'b1;
    bus.branch_taken = 1'b0;
    bus.branch_target = 32'd0;
    bus.imem_data = 32'd0;
    wbus.if_ready = 1'b1;
    wbus.branch_taken = 1'b0;
    wbus.branch_target = 32'd0;
    wbus.imem_data = 32'd0;
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect();
    test_redirect_full_pop();
    test_wrap();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
